// File: rtl/simple_fixed_shift_pipe.sv
// simple_fixed_shift_pipe
// Shift/rotate execution stage for the even pipe. The per-slot result for
// halfword or word shift/rotate/rotate-and-mask is computed combinationally
// from the issue inputs, captured in stage 1, then carried through
// LATENCY-1 delay stages to the writeback outputs. Supports stall, flush
// and a one-shot writeback enable.
module simple_fixed_shift_pipe #(
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [2:0]   op_sel,
  input  logic         use_imm,
  input  logic [6:0]   imm7,
  input  logic [6:0]   rt_addr,
  input  logic [127:0] register_RA,
  input  logic [127:0] register_RB,
  input  logic         stall,
  input  logic         flush,
  output logic         out_valid,
  output logic         wb_en,
  output logic [6:0]   out_rt_addr,
  output logic [127:0] register_RT,
  output logic         busy
);

  // Halfword operation; kind is op_sel[2:1] (shlh, roth, rothm, rotmah).
  // Only the low five count bits ever matter after masking.
  function automatic logic [15:0] half_op(input logic [1:0] kind,
                                          input logic [15:0] a,
                                          input logic [4:0] c);
    logic [4:0]         n;
    logic signed [15:0] sa;
    logic [15:0]        r;
    n  = 5'd0 - c;
    sa = a;
    r  = 16'h0000;
    case (kind)
      2'd0: begin
        if (c[4]) r = 16'h0000;
        else      r = a << c[3:0];
      end
      2'd1: r = (a << c[3:0]) | (a >> (5'd16 - {1'b0, c[3:0]}));
      2'd2: begin
        if (n[4]) r = 16'h0000;
        else      r = a >> n[3:0];
      end
      2'd3: begin
        if (n[4]) r = {16{a[15]}};
        else      r = sa >>> n[3:0];
      end
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // Word operation; kind is op_sel[2:1] (shl, rot, rotm, rotma).
  // Only the low six count bits ever matter after masking.
  function automatic logic [31:0] word_op(input logic [1:0] kind,
                                          input logic [31:0] a,
                                          input logic [5:0] c);
    logic [5:0]         n;
    logic signed [31:0] sa;
    logic [31:0]        r;
    n  = 6'd0 - c;
    sa = a;
    r  = 32'h0000_0000;
    case (kind)
      2'd0: begin
        if (c[5]) r = 32'h0000_0000;
        else      r = a << c[4:0];
      end
      2'd1: r = (a << c[4:0]) | (a >> (6'd32 - {1'b0, c[4:0]}));
      2'd2: begin
        if (n[5]) r = 32'h0000_0000;
        else      r = a >> n[4:0];
      end
      2'd3: begin
        if (n[5]) r = {32{a[31]}};
        else      r = sa >>> n[4:0];
      end
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  logic [127:0]        half_res_s;
  logic [127:0]        word_res_s;
  logic [127:0]        result_d;
  logic                accept_s;
  logic [LATENCY-1:0]  valid_q;
  logic [6:0]          rt_q   [LATENCY];
  logic [127:0]        data_q [LATENCY];

  // Count bits above the masked field and the top immediate bit never affect
  // a result, because sign extension followed by masking keeps only the low
  // five or six bits.
  logic                unused_cnt_bits_s;
  assign unused_cnt_bits_s = ^{register_RB, imm7[6]};

  assign accept_s = in_valid & ~stall & ~flush;

  // Halfword results for all eight slots, each with its own count.
  always_comb begin
    half_res_s = 128'h0;
    for (int h = 0; h < 8; h++) begin
      half_res_s[h*16 +: 16] = half_op(op_sel[2:1], register_RA[h*16 +: 16],
                                       use_imm ? imm7[4:0] : register_RB[h*16 +: 5]);
    end
  end

  // Word results for all four slots, each with its own count.
  always_comb begin
    word_res_s = 128'h0;
    for (int w = 0; w < 4; w++) begin
      word_res_s[w*32 +: 32] = word_op(op_sel[2:1], register_RA[w*32 +: 32],
                                       use_imm ? imm7[5:0] : register_RB[w*32 +: 6]);
    end
  end

  // Stage 1 data: odd opcodes are word forms, even opcodes halfword forms.
  always_comb begin
    result_d = 128'h0;
    if (op_sel[0]) result_d = word_res_s;
    else           result_d = half_res_s;
  end

  // Pipeline advance with reset > flush > stall > advance priority; data
  // registers only load behind a valid bit so bubbles keep stale contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        rt_q[i]   <= 7'h00;
        data_q[i] <= 128'h0;
      end
    end else if (flush) begin
      valid_q <= {LATENCY{1'b0}};
    end else if (!stall) begin
      valid_q <= {valid_q[LATENCY-2:0], accept_s};
      if (accept_s) begin
        rt_q[0]   <= rt_addr;
        data_q[0] <= result_d;
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (valid_q[i-1]) begin
          rt_q[i]   <= rt_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid   = valid_q[LATENCY-1];
  assign out_rt_addr = rt_q[LATENCY-1];
  assign register_RT = data_q[LATENCY-1];
  assign busy        = |valid_q;
  // A final-stage instruction being killed this cycle must not write back.
  assign wb_en       = valid_q[LATENCY-1] & ~stall & ~flush & ~reset;

endmodule

// File: tb/tb_simple_fixed_shift_pipe.sv
// Directed bench for simple_fixed_shift_pipe with LATENCY=4.
module tb_simple_fixed_shift_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [2:0]   op_sel;
  logic         use_imm;
  logic [6:0]   imm7;
  logic [6:0]   rt_addr;
  logic [127:0] register_RA;
  logic [127:0] register_RB;
  logic         stall;
  logic         flush;
  logic         out_valid;
  logic         wb_en;
  logic [6:0]   out_rt_addr;
  logic [127:0] register_RT;
  logic         busy;

  int total = 0;
  int bad   = 0;

  simple_fixed_shift_pipe #(.LATENCY(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op_sel(op_sel),
    .use_imm(use_imm), .imm7(imm7), .rt_addr(rt_addr),
    .register_RA(register_RA), .register_RB(register_RB),
    .stall(stall), .flush(flush), .out_valid(out_valid), .wb_en(wb_en),
    .out_rt_addr(out_rt_addr), .register_RT(register_RT), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction alone and follow it to writeback.
  task automatic run_op(input string tag, input logic [2:0] op, input logic ui,
                        input logic [6:0] imm, input logic [6:0] rt,
                        input logic [127:0] ra, input logic [127:0] rb,
                        input logic [127:0] exp);
    in_valid = 1'b1; op_sel = op; use_imm = ui; imm7 = imm; rt_addr = rt;
    register_RA = ra; register_RB = rb;
    tick();
    in_valid = 1'b0; register_RA = 128'h0; register_RB = 128'h0;
    chk({tag, "_busy_s1"}, {127'h0, busy}, 128'h1);
    chk({tag, "_ov_s1"}, {127'h0, out_valid}, 128'h0);
    tick();
    tick();
    chk({tag, "_ov_s3"}, {127'h0, out_valid}, 128'h0);
    tick();
    chk({tag, "_ov"}, {127'h0, out_valid}, 128'h1);
    chk({tag, "_wb"}, {127'h0, wb_en}, 128'h1);
    chk({tag, "_rt"}, {121'h0, out_rt_addr}, {121'h0, rt});
    chk({tag, "_data"}, register_RT, exp);
    tick();
    chk({tag, "_ov_after"}, {127'h0, out_valid}, 128'h0);
    chk({tag, "_busy_after"}, {127'h0, busy}, 128'h0);
  endtask

  task automatic issue(input logic [6:0] rt, input logic [127:0] ra);
    in_valid = 1'b1; op_sel = 3'd0; use_imm = 1'b0; imm7 = 7'h00;
    rt_addr = rt; register_RA = ra; register_RB = 128'h0;
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op_sel = 3'd0; use_imm = 1'b0; imm7 = 7'h00;
    rt_addr = 7'h00; register_RA = 128'h0; register_RB = 128'h0;
    stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ov", {127'h0, out_valid}, 128'h0);
    chk("rst_wb", {127'h0, wb_en}, 128'h0);
    chk("rst_busy", {127'h0, busy}, 128'h0);
    chk("rst_rt", {121'h0, out_rt_addr}, 128'h0);
    chk("rst_data", register_RT, 128'h0);

    run_op("shlh", 3'd0, 1'b0, 7'h00, 7'd5, {8{16'h8001}},
           {16'h0002, 16'hFFE0, 16'h001F, 16'h000F, 16'h0000, 16'h0021, 16'h0010, 16'h0001},
           {16'h0004, 16'h8001, 16'h0000, 16'h8000, 16'h8001, 16'h0002, 16'h0000, 16'h0002});
    run_op("rotmah", 3'd6, 1'b0, 7'h00, 7'd6, {8{16'h8000}},
           {{4{16'hFFFE}}, 16'hFFF1, 16'h0000, 16'hFFF0, 16'hFFFF},
           {{4{16'hE000}}, 16'hFFFF, 16'h8000, 16'hFFFF, 16'hC000});
    run_op("rotma", 3'd7, 1'b0, 7'h00, 7'd7,
           {32'h12345678, 32'h80000000, 32'h80000000, 32'h7FFF0000},
           {32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFE0, 32'hFFFFFFF0},
           {32'h12345678, 32'hF8000000, 32'hFFFFFFFF, 32'h00007FFF});
    run_op("rot", 3'd3, 1'b0, 7'h00, 7'd8,
           {32'hDEADBEEF, 32'h12345678, 32'h80000001, 32'h80000001},
           {32'h00000000, 32'h00000008, 32'h00000021, 32'h00000004},
           {32'hDEADBEEF, 32'h34567812, 32'h00000003, 32'h00000018});
    run_op("roth_imm", 3'd2, 1'b1, 7'h7F, 7'd9, {8{16'h0001}}, {8{16'h0003}},
           {8{16'h8000}});
    run_op("shl", 3'd1, 1'b0, 7'h00, 7'd10, {4{32'h00000001}},
           {32'h00000044, 32'h0000003F, 32'h00000020, 32'h0000001F},
           {32'h00000010, 32'h00000000, 32'h00000000, 32'h80000000});
    run_op("shl_imm", 3'd1, 1'b1, 7'h60, 7'd11, {4{32'h00000001}}, {4{32'h00000001}},
           128'h0);
    run_op("rothm", 3'd4, 1'b0, 7'h00, 7'd12, {8{16'h8000}},
           {{4{16'hFFFC}}, 16'hFFF1, 16'h0000, 16'hFFF0, 16'hFFFF},
           {{4{16'h0800}}, 16'h0001, 16'h8000, 16'h0000, 16'h4000});
    run_op("rotm", 3'd5, 1'b0, 7'h00, 7'd13, {4{32'h80000000}},
           {32'h00000000, 32'hFFFFFFE1, 32'hFFFFFFFF, 32'hFFFFFFE0},
           {32'h80000000, 32'h00000001, 32'h40000000, 32'h00000000});

    // Back-to-back issue with a two-cycle stall when the first reaches output.
    issue(7'd20, {8{16'h1111}});
    issue(7'd21, {8{16'h2222}});
    issue(7'd22, {8{16'h3333}});
    in_valid = 1'b0;
    tick();
    stall = 1'b1;
    #1;
    chk("stall0_ov", {127'h0, out_valid}, 128'h1);
    chk("stall0_wb", {127'h0, wb_en}, 128'h0);
    chk("stall0_rt", {121'h0, out_rt_addr}, 128'd20);
    tick();
    chk("stall1_ov", {127'h0, out_valid}, 128'h1);
    chk("stall1_wb", {127'h0, wb_en}, 128'h0);
    chk("stall1_rt", {121'h0, out_rt_addr}, 128'd20);
    tick();
    stall = 1'b0;
    #1;
    chk("b2b0_wb", {127'h0, wb_en}, 128'h1);
    chk("b2b0_rt", {121'h0, out_rt_addr}, 128'd20);
    chk("b2b0_data", register_RT, {8{16'h1111}});
    tick();
    chk("b2b1_wb", {127'h0, wb_en}, 128'h1);
    chk("b2b1_rt", {121'h0, out_rt_addr}, 128'd21);
    tick();
    chk("b2b2_wb", {127'h0, wb_en}, 128'h1);
    chk("b2b2_rt", {121'h0, out_rt_addr}, 128'd22);
    chk("b2b2_data", register_RT, {8{16'h3333}});
    tick();
    chk("b2b_end_ov", {127'h0, out_valid}, 128'h0);
    chk("b2b_end_busy", {127'h0, busy}, 128'h0);

    // Flush after two accepts, with a third instruction offered alongside.
    issue(7'd30, {8{16'h4444}});
    issue(7'd31, {8{16'h5555}});
    flush = 1'b1; in_valid = 1'b1; rt_addr = 7'd32;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", {127'h0, busy}, 128'h0);
    for (int i = 0; i < 5; i++) begin
      chk("flush_wb", {127'h0, wb_en}, 128'h0);
      chk("flush_ov", {127'h0, out_valid}, 128'h0);
      tick();
    end
    run_op("post_flush", 3'd0, 1'b0, 7'h00, 7'd33, {8{16'h6666}}, 128'h0,
           {8{16'h6666}});

    // Reset with three instructions in flight, then held with in_valid high.
    issue(7'd40, {8{16'h7777}});
    issue(7'd41, {8{16'h8888}});
    issue(7'd42, {8{16'h9999}});
    reset = 1'b1; rt_addr = 7'd43;
    tick();
    chk("rstf_ov", {127'h0, out_valid}, 128'h0);
    chk("rstf_wb", {127'h0, wb_en}, 128'h0);
    chk("rstf_busy", {127'h0, busy}, 128'h0);
    chk("rstf_rt", {121'h0, out_rt_addr}, 128'h0);
    chk("rstf_data", register_RT, 128'h0);
    tick();
    chk("rsthold_busy", {127'h0, busy}, 128'h0);
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rst_after_wb", {127'h0, wb_en}, 128'h0);
      chk("rst_after_ov", {127'h0, out_valid}, 128'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
